// File: rtl/alu_operand_stage.sv
// Operand-select pipeline register between register read and the ALU, with x0/EX/WB bypass.
// Define ALU_OPERAND_FWD_EX_EN to forward ex_result; otherwise RAW hazards on the held op stall.
module alu_operand_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_regwrite,
    input  logic [DATA_WIDTH-1:0] in_rd1,
    input  logic [DATA_WIDTH-1:0] in_rd2,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic                  in_alusrc,
    input  logic [2:0]            in_aluctrl,
    input  logic                  flush,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [DATA_WIDTH-1:0] ex_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_regwrite
);

    logic                  valid_q, valid_d;
    logic                  regwrite_q, regwrite_d;
    logic [DATA_WIDTH-1:0] op1_q, op2_q;
    logic [DATA_WIDTH-1:0] op1_d, op2_d;
    logic [2:0]            ctrl_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  stall;
    logic                  load;
    logic                  capture;

    function automatic logic [DATA_WIDTH-1:0] resolve(input logic [ADDR_WIDTH-1:0] rs,
                                                      input logic [DATA_WIDTH-1:0] rf_val);
        logic [DATA_WIDTH-1:0] val;
        val = rf_val;
        if (wb_we && wb_rd == rs) val = wb_data;
`ifdef ALU_OPERAND_FWD_EX_EN
        if (valid_q && regwrite_q && rd_q == rs) val = ex_result;
`endif
        if (rs == '0) val = '0;
        return val;
    endfunction

`ifdef ALU_OPERAND_FWD_EX_EN
    assign stall = 1'b0;
`else
    logic unused_ex_result;
    assign unused_ex_result = ^ex_result;

    // Held producer's result is not yet visible; wait until it has left and reaches WB/RF.
    assign stall = valid_q && regwrite_q && (rd_q != '0) &&
                   ((rd_q == in_rs1) || ((rd_q == in_rs2) && !in_alusrc));
`endif

    assign in_ready = (!valid_q || out_ready) && !stall;
    assign load     = in_valid && in_ready;
    assign capture  = load && !flush;

    always_comb begin
        op1_d = resolve(in_rs1, in_rd1);
        op2_d = in_alusrc ? in_imm : resolve(in_rs2, in_rd2);
    end

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (load) begin
            valid_d    = 1'b1;
            regwrite_d = in_regwrite && (in_rd != '0);
        end else if (out_ready) begin
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            ctrl_q     <= 3'b000;
            rd_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            if (capture) begin
                op1_q  <= op1_d;
                op2_q  <= op2_d;
                ctrl_q <= in_aluctrl;
                rd_q   <= in_rd;
            end
        end
    end

    assign out_valid    = valid_q;
    assign ALUop1       = op1_q;
    assign ALUop2       = op2_q;
    assign ALUctrl      = ctrl_q;
    assign out_rd       = rd_q;
    assign out_regwrite = regwrite_q;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline register plus operand-select stage between decode/register-file read and the combinational ALU.
- Captures register read data, immediate and control for one instruction, and applies register bypassing so the ALU sees up-to-date operands.
- Selects register or immediate for the second operand.
- Registered outputs drive ALUop1, ALUop2 and ALUctrl directly, with a valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 32, operand/result width
- ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_rs1  in  ADDR_WIDTH  source register 1 index
- in_rs2  in  ADDR_WIDTH  source register 2 index
- in_rd  in  ADDR_WIDTH  destination index
- in_regwrite  in  1  instruction writes rd
- in_rd1  in  DATA_WIDTH  register file read data 1
- in_rd2  in  DATA_WIDTH  register file read data 2
- in_imm  in  DATA_WIDTH  sign-extended immediate
- in_alusrc  in  1  1 = op2 from immediate
- in_aluctrl  in  3  ALU operation code
- flush  in  1  discard held and incoming instruction
- wb_we  in  1  writeback port write enable
- wb_rd  in  ADDR_WIDTH  writeback destination
- wb_data  in  DATA_WIDTH  writeback data
- ex_result  in  DATA_WIDTH  ALU SUM of held instruction
- out_valid  out  1  ALU operands valid
- out_ready  in  1  downstream accepts
- ALUop1  out  DATA_WIDTH  registered operand 1
- ALUop2  out  DATA_WIDTH  registered operand 2
- ALUctrl  out  3  registered ALU op
- out_rd  out  ADDR_WIDTH  held destination
- out_regwrite  out  1  held write enable

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0; ALUop1, ALUop2, out_rd, out_regwrite=0; ALUctrl=3'b000. Reset mid-operation drops the held instruction and takes effect immediately, without waiting for clk.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Transfer on a rising edge when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Held outputs stay stable while out_valid && !out_ready.
- State: single-entry register, EMPTY (out_valid=0) / FULL (out_valid=1).
  - EMPTY -> FULL on input transfer.
  - FULL -> FULL on simultaneous output and input transfer (new instruction loaded).
  - FULL -> EMPTY on output transfer with no input.
- Latency: operands appear on ALUop* one cycle after the input transfer.
- Operand resolution, combinational on the input side, priority high to low:
  - Index 0 always resolves to 0, and is never bypassed.
  - EX bypass: out_valid && out_regwrite && out_rd==rs -> ex_result.
  - WB bypass: wb_we && wb_rd==rs -> wb_data.
  - Otherwise in_rd1/in_rd2.
- ALUop2 = in_imm when in_alusrc=1; the rs2 bypass result otherwise. Bypass on rs2 still applies when in_alusrc=0.
- flush (synchronous, sampled at the edge):
  - Next state EMPTY; out_valid=0 regardless of in_valid.
  - Overrides input transfer.
  - Data registers need not clear; out_regwrite clears to 0.
- in_regwrite with in_rd==0: captured as out_regwrite=0.
- Bubble: when FULL and out_ready=1 and in_valid=0, the stage goes EMPTY. The EX bypass is qualified by out_valid, so a departed instruction is never forwarded.

Optional Feature:
- Macro: ALU_OPERAND_FWD_EX_EN.
- Defined: EX bypass as above; full throughput on back-to-back dependent instructions.
- Undefined:
  - No EX bypass path; ex_result is ignored.
  - Hazard stall instead: in_ready is additionally forced 0 while out_valid && out_regwrite && out_rd!=0 && (out_rd==in_rs1 || (out_rd==in_rs2 && !in_alusrc)).
  - The dependent instruction enters after the producer leaves and receives its value via WB bypass, or via the register file.
- WB bypass and x0 rules are unchanged in both builds.

Test Plan:
- Reset with rst_n pulsed low mid-cycle while FULL -> out_valid=0, ALUop1=0, ALUctrl=0 immediately, asynchronously.
- Single transfer rd1=5, rd2=7, alusrc=0, aluctrl=001 -> next cycle ALUop1=5, ALUop2=7, ALUctrl=001, out_valid=1.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs held; out_ready=1 -> next instruction loads in the same cycle.
- Producer rd=3, ex_result=0x10, followed by consumer rs1=3 (feature on) -> ALUop1=0x10 with no stall. Feature off -> in_ready=0 for one cycle; consumer then takes wb_data for x3.
- wb_we=1, wb_rd=4, wb_data=0xAA with rs2=4, alusrc=1, imm=0x8 -> ALUop2=0x8. Same with alusrc=0 -> ALUop2=0xAA.
- rs1=0 with wb_rd=0, wb_data=0xFF, and flush asserted together with in_valid -> no ALUop1=0xFF is ever seen, and the flushed instruction never appears: out_valid=0.
